// File: rtl/rbot_pkg.sv
// Move codes and batch geometry shared by move_batcher and update_state.
package rbot_pkg;

    localparam int N_MOVES = 50;
    localparam int MOVE_W  = 4;

    localparam logic [MOVE_W-1:0] MV_NOP = 4'd0;
    localparam logic [MOVE_W-1:0] MV_R   = 4'd2;
    localparam logic [MOVE_W-1:0] MV_RI  = 4'd3;
    localparam logic [MOVE_W-1:0] MV_U   = 4'd4;
    localparam logic [MOVE_W-1:0] MV_UI  = 4'd5;
    localparam logic [MOVE_W-1:0] MV_F   = 4'd6;
    localparam logic [MOVE_W-1:0] MV_FI  = 4'd7;
    localparam logic [MOVE_W-1:0] MV_L   = 4'd8;
    localparam logic [MOVE_W-1:0] MV_LI  = 4'd9;
    localparam logic [MOVE_W-1:0] MV_B   = 4'd10;
    localparam logic [MOVE_W-1:0] MV_BI  = 4'd11;
    localparam logic [MOVE_W-1:0] MV_D   = 4'd12;
    localparam logic [MOVE_W-1:0] MV_DI  = 4'd13;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } batch_state_t;

    // Codes 1, 14 and 15 have no meaning downstream.
    function automatic logic is_legal_move(input logic [MOVE_W-1:0] code);
        return !((code == 4'd1) || (code == 4'd14) || (code == 4'd15));
    endfunction

endpackage

// File: rtl/move_batcher.sv
// Packs single move codes into a 50-slot move word for update_state and
// holds the issued batch until update_state signals completion.
module move_batcher #(
    parameter int N_MOVES = rbot_pkg::N_MOVES,
    parameter int MOVE_W  = rbot_pkg::MOVE_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [MOVE_W-1:0]          move_in,
    input  logic                       move_valid,
    output logic                       move_ready,
    input  logic                       flush,
    input  logic                       state_updated,
    output logic [N_MOVES*MOVE_W-1:0]  moves,
    output logic                       new_moves_ready,
    output logic                       busy,
    output logic                       invalid_seen,
    output logic [7:0]                 batch_count
);
    import rbot_pkg::*;

    localparam int TOTAL_W = N_MOVES * MOVE_W;
    localparam int CNT_W   = $clog2(N_MOVES + 1);
    localparam int SH_W    = $clog2(TOTAL_W);

    batch_state_t         state, state_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic [TOTAL_W-1:0]   moves_nxt;
    logic [TOTAL_W-1:0]   slot_word;
    logic [SH_W-1:0]      shamt;
    logic                 nmr_nxt, busy_nxt, inv_nxt;
    logic [7:0]           bc_nxt;
    logic                 accept, legal;

    assign move_ready = (state == ST_FILL) && (count < CNT_W'(N_MOVES));

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        moves_nxt = moves;
        nmr_nxt   = 1'b0;
        busy_nxt  = busy;
        inv_nxt   = invalid_seen;
        bc_nxt    = batch_count;
        accept    = 1'b0;
        legal     = is_legal_move(move_in);
        shamt     = SH_W'(int'(count) * MOVE_W);
        // Slot 0 sits in the MSBs, so slot k is the top nibble shifted right.
        slot_word = {move_in, {(TOTAL_W-MOVE_W){1'b0}}} >> shamt;

        case (state)
            ST_FILL: begin
                accept = move_valid && move_ready;
                if (accept) begin
                    if (legal) begin
                        moves_nxt = moves | slot_word;
                        count_nxt = count + 1'b1;
                    end else begin
                        inv_nxt = 1'b1;
                    end
                end
                if ((accept && legal && (count_nxt == CNT_W'(N_MOVES))) ||
                    (flush && (count_nxt != '0))) begin
                    state_nxt = ST_ISSUE;
                    nmr_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    bc_nxt    = batch_count + 8'd1;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (state_updated) begin
                    state_nxt = ST_FILL;
                    moves_nxt = '0;
                    count_nxt = '0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_FILL;
                moves_nxt = '0;
                count_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_FILL;
            count           <= '0;
            moves           <= '0;
            new_moves_ready <= 1'b0;
            busy            <= 1'b0;
            invalid_seen    <= 1'b0;
            batch_count     <= 8'd0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            moves           <= moves_nxt;
            new_moves_ready <= nmr_nxt;
            busy            <= busy_nxt;
            invalid_seen    <= inv_nxt;
            batch_count     <= bc_nxt;
        end
    end

endmodule

// File: tb/tb_move_batcher.sv
// Directed bench for move_batcher with hand-computed expected batches.
module tb_move_batcher;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   move_in = 4'd0;
    logic         move_valid = 1'b0;
    logic         move_ready;
    logic         flush = 1'b0;
    logic         state_updated = 1'b0;
    logic [199:0] moves;
    logic         new_moves_ready;
    logic         busy;
    logic         invalid_seen;
    logic [7:0]   batch_count;

    int n_checks = 0;
    int n_err = 0;

    move_batcher dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .move_in         (move_in),
        .move_valid      (move_valid),
        .move_ready      (move_ready),
        .flush           (flush),
        .state_updated   (state_updated),
        .moves           (moves),
        .new_moves_ready (new_moves_ready),
        .busy            (busy),
        .invalid_seen    (invalid_seen),
        .batch_count     (batch_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [3:0] code);
        move_in    = code;
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic do_done();
        state_updated = 1'b1;
        tick();
        state_updated = 1'b0;
    endtask

    initial begin
        // Reset with no stimulus
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_moves", moves, '0);
        check("rst_nmr", 200'(new_moves_ready), 200'(0));
        check("rst_busy", 200'(busy), 200'(0));
        check("rst_ready", 200'(move_ready), 200'(1));
        check("rst_bc", 200'(batch_count), 200'(0));
        check("rst_inv", 200'(invalid_seen), 200'(0));

        // 2, 4, 6 then flush
        send(4'd2);
        send(4'd4);
        send(4'd6);
        check("p1_no_pulse_yet", 200'(new_moves_ready), 200'(0));
        do_flush();
        check("p1_pulse", 200'(new_moves_ready), 200'(1));
        check("p1_busy", 200'(busy), 200'(1));
        check("p1_ready", 200'(move_ready), 200'(0));
        check("p1_moves", moves, {12'h246, 188'd0});
        check("p1_bc", 200'(batch_count), 200'(1));
        tick();
        check("p1_pulse_end", 200'(new_moves_ready), 200'(0));
        check("p1_busy_hold", 200'(busy), 200'(1));
        do_flush();
        tick();
        check("p1_moves_hold", moves, {12'h246, 188'd0});
        check("p1_bc_hold", 200'(batch_count), 200'(1));
        do_done();
        check("p1_done_ready", 200'(move_ready), 200'(1));
        check("p1_done_busy", 200'(busy), 200'(0));
        check("p1_done_moves", moves, '0);

        // 50 x code 2, auto-issue; 51st move held off
        move_in    = 4'd2;
        move_valid = 1'b1;
        for (int i = 0; i < 49; i++) tick();
        check("p2_no_pulse_49", 200'(new_moves_ready), 200'(0));
        tick();
        check("p2_pulse", 200'(new_moves_ready), 200'(1));
        check("p2_moves", moves, {50{4'h2}});
        check("p2_bc", 200'(batch_count), 200'(2));
        move_in = 4'd4;
        tick();
        tick();
        check("p2_ready_low", 200'(move_ready), 200'(0));
        check("p2_moves_hold", moves, {50{4'h2}});
        state_updated = 1'b1;
        tick();
        state_updated = 1'b0;
        check("p2_ready_back", 200'(move_ready), 200'(1));
        check("p2_cleared", moves, '0);
        tick();
        move_valid = 1'b0;
        check("p2_next_batch", moves, {4'h4, 196'd0});
        check("p2_no_pulse", 200'(new_moves_ready), 200'(0));
        do_flush();
        check("p2b_bc", 200'(batch_count), 200'(3));
        tick();
        do_done();

        // Illegal code between 2 and 3
        send(4'd2);
        send(4'd15);
        check("p3_inv", 200'(invalid_seen), 200'(1));
        send(4'd3);
        do_flush();
        check("p3_moves", moves, {8'h23, 192'd0});
        check("p3_bc", 200'(batch_count), 200'(4));
        tick();
        do_done();
        check("p3_inv_sticky", 200'(invalid_seen), 200'(1));

        // Flush with empty batch
        do_flush();
        check("p4_no_pulse", 200'(new_moves_ready), 200'(0));
        check("p4_busy", 200'(busy), 200'(0));
        check("p4_bc", 200'(batch_count), 200'(4));
        check("p4_ready", 200'(move_ready), 200'(1));

        // Move 5 with flush on the same edge
        move_in    = 4'd5;
        move_valid = 1'b1;
        flush      = 1'b1;
        tick();
        move_valid = 1'b0;
        flush      = 1'b0;
        check("p5_pulse", 200'(new_moves_ready), 200'(1));
        check("p5_moves", moves, {4'h5, 196'd0});
        check("p5_bc", 200'(batch_count), 200'(5));
        tick();
        check("p5_wait_busy", 200'(busy), 200'(1));

        // Reset during WAIT
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        check("p6_rst_moves", moves, '0);
        check("p6_rst_busy", 200'(busy), 200'(0));
        check("p6_rst_bc", 200'(batch_count), 200'(0));
        check("p6_rst_inv", 200'(invalid_seen), 200'(0));
        check("p6_rst_nmr", 200'(new_moves_ready), 200'(0));
        tick();
        reset_n = 1'b1;
        tick();
        do_done();
        check("p6_su_ready", 200'(move_ready), 200'(1));
        check("p6_su_busy", 200'(busy), 200'(0));
        check("p6_su_moves", moves, '0);
        check("p6_su_nmr", 200'(new_moves_ready), 200'(0));
        send(4'd12);
        check("p6_fresh_slot0", moves, {4'hc, 196'd0});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
